// File: rtl/button_cmd_encoder.sv
// button_cmd_encoder
//   Front end for the breakout game core. Each raw switch is synchronised,
//   debounced and edge-detected. LEFT/RIGHT auto-repeat while held. Each press
//   or repeat becomes a 2-bit command in a small FWFT FIFO that the game core
//   pops with valid/ready.
// Ports
//   buttonclk            clock, rising edge
//   reset                synchronous, active-high
//   enable               game running; low flushes queue and drops events
//   raw_left/right/throw asynchronous switch inputs, active-high
//   cmd_valid/cmd_code   registered FIFO head (01 LEFT, 10 RIGHT, 11 THROW)
//   cmd_ready            pop on cmd_valid && cmd_ready
//   fifo_count           occupancy, including an entry pushed but not yet shown
//   overrun              sticky: event merged into an already-pending one
module button_cmd_encoder #(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int HOLD_TICKS     = 6,
  parameter int REPEAT_TICKS   = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                         buttonclk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         raw_left,
  input  logic                         raw_right,
  input  logic                         raw_throw,
  output logic                         cmd_valid,
  output logic [1:0]                   cmd_code,
  input  logic                         cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overrun
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int DBW     = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RPT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int RW      = $clog2(RPT_MAX + 1);

  // Button index: 0 LEFT, 1 RIGHT, 2 THROW
  logic [2:0]          raw, sync1, sync2, db, db_prev, rise;
  logic [2:0][DBW-1:0] db_cnt;
  logic                both;

  assign raw  = {raw_throw, raw_right, raw_left};
  assign rise = db & ~db_prev;
  assign both = db[0] & db[1];

  // Sync and debounce keep running while enable is low, so db_prev tracks a
  // button held across enable rising and no press is seen for it.
  always_ff @(posedge buttonclk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_prev <= '0;
      db_cnt  <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db;
      for (int b = 0; b < 3; b++) begin
        if (sync2[b] == db[b])
          db_cnt[b] <= '0;
        else if (db_cnt[b] == DBW'(DEBOUNCE_TICKS - 1)) begin
          db[b]     <= ~db[b];
          db_cnt[b] <= '0;
        end else
          db_cnt[b] <= db_cnt[b] + DBW'(1);
      end
    end
  end

  // Repeat counters: zero means "not armed". A press arms the counter at 1;
  // it counts held cycles and fires at HOLD_TICKS, then every REPEAT_TICKS.
  logic [1:0][RW-1:0] rep_cnt, rep_cnt_n;
  logic [1:0]         in_rep, in_rep_n;
  logic [2:0]         evt;

  always_comb begin
    evt       = '0;
    rep_cnt_n = rep_cnt;
    in_rep_n  = in_rep;
    evt[2]    = enable & rise[2];
    for (int m = 0; m < 2; m++) begin
      if (!enable || !db[m] || both) begin
        rep_cnt_n[m] = '0;
        in_rep_n[m]  = 1'b0;
      end else if (rise[m]) begin
        evt[m]       = 1'b1;
        rep_cnt_n[m] = RW'(1);
        in_rep_n[m]  = 1'b0;
      end else if (rep_cnt[m] != '0) begin
        if (rep_cnt[m] == (in_rep[m] ? RW'(REPEAT_TICKS) : RW'(HOLD_TICKS))) begin
          evt[m]       = 1'b1;
          rep_cnt_n[m] = RW'(1);
          in_rep_n[m]  = 1'b1;
        end else
          rep_cnt_n[m] = rep_cnt[m] + RW'(1);
      end
    end
  end

  // Arbiter: THROW > LEFT > RIGHT, at most one push per cycle.
  logic [2:0]              pend, pend_n, grant_sel, grant;
  logic [1:0]              push_code;
  logic                    push, pop, full;
  logic [FIFO_DEPTH-1:0][1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr, rd_n;
  logic [CW-1:0]           remain, count_n;
  logic [1:0]              head_n;

  always_comb begin
    grant_sel = '0;
    push_code = 2'b00;
    if (pend[2]) begin
      grant_sel = 3'b100;
      push_code = 2'b11;
    end else if (pend[0]) begin
      grant_sel = 3'b001;
      push_code = 2'b01;
    end else if (pend[1]) begin
      grant_sel = 3'b010;
      push_code = 2'b10;
    end
  end

  assign full   = (fifo_count == CW'(FIFO_DEPTH));
  assign pop    = enable & cmd_valid & cmd_ready;
  assign push   = enable & (|pend) & (~full | pop);
  assign grant  = push ? grant_sel : 3'b000;
  assign pend_n = enable ? ((pend & ~grant) | evt) : 3'b000;

  // The head register only shows entries stored before this edge, so a
  // freshly pushed entry appears one cycle after it lands in the FIFO.
  always_comb begin
    rd_n    = rd_ptr + AW'(pop);
    remain  = fifo_count - CW'(pop);
    count_n = remain + CW'(push);
    head_n  = (remain != '0) ? mem[rd_n] : 2'b00;
  end

  always_ff @(posedge buttonclk) begin
    if (reset) begin
      pend       <= '0;
      overrun    <= 1'b0;
      rep_cnt    <= '0;
      in_rep     <= '0;
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cmd_valid  <= 1'b0;
      cmd_code   <= 2'b00;
    end else begin
      pend    <= pend_n;
      rep_cnt <= rep_cnt_n;
      in_rep  <= in_rep_n;
      if (|(evt & pend & ~grant))
        overrun <= 1'b1;
      if (!enable) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        cmd_valid  <= 1'b0;
        cmd_code   <= 2'b00;
      end else begin
        if (push) begin
          mem[wr_ptr] <= push_code;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        rd_ptr     <= rd_n;
        fifo_count <= count_n;
        cmd_valid  <= (remain != '0);
        cmd_code   <= head_n;
      end
    end
  end
endmodule

// File: tb/tb_button_cmd_encoder.sv
module tb_button_cmd_encoder;
  localparam int D     = 2;
  localparam int H     = 6;
  localparam int R     = 2;
  localparam int DEPTH = 4;

  logic       buttonclk = 1'b0;
  logic       reset, enable, cmd_ready;
  logic [2:0] raws;   // {throw, right, left}
  logic       cmd_valid, overrun;
  logic [1:0] cmd_code;
  logic [2:0] fifo_count;

  button_cmd_encoder #(
    .DEBOUNCE_TICKS(D), .HOLD_TICKS(H), .REPEAT_TICKS(R), .FIFO_DEPTH(DEPTH)
  ) dut (
    .buttonclk (buttonclk),
    .reset     (reset),
    .enable    (enable),
    .raw_left  (raws[0]),
    .raw_right (raws[1]),
    .raw_throw (raws[2]),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .fifo_count(fifo_count),
    .overrun   (overrun)
  );

  always #5 buttonclk = ~buttonclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0d, want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-button sample history and run length, "armed" move
  // timers counted in cycles since press, pending bits and a command queue.
  bit         m_s1[3], m_s2[3], m_db[3], m_dbp[3];
  int         m_run[3];
  bit         m_arm[2];
  int         m_k[2];
  bit         m_pend[3];
  bit         m_ovr, m_valid;
  logic [1:0] m_code;
  logic [1:0] m_q[$];

  task automatic model_step(input logic rst, input logic en, input logic [2:0] raw, input logic rdy);
    bit rise[3];
    bit ev[3];
    bit both, pop;
    int g;
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbp[b] = 0; m_run[b] = 0; m_pend[b] = 0;
      end
      for (int m = 0; m < 2; m++) begin m_arm[m] = 0; m_k[m] = 0; end
      m_ovr = 0; m_valid = 0; m_code = 0;
      m_q.delete();
      return;
    end
    for (int b = 0; b < 3; b++) begin
      rise[b] = m_db[b] && !m_dbp[b];
      ev[b]   = 0;
    end
    both = m_db[0] && m_db[1];
    if (en) begin
      ev[2] = rise[2];
      for (int m = 0; m < 2; m++) begin
        if (!m_db[m] || both) m_arm[m] = 0;
        else if (rise[m]) begin ev[m] = 1; m_arm[m] = 1; m_k[m] = 1; end
        else if (m_arm[m]) begin
          if (m_k[m] == H || (m_k[m] > H && (m_k[m] - H) % R == 0)) ev[m] = 1;
          m_k[m]++;
        end
      end
    end else begin
      m_arm[0] = 0; m_arm[1] = 0;
    end
    pop = en && m_valid && rdy;
    g = -1;
    if (en && (m_q.size() < DEPTH || pop)) begin
      if (m_pend[2]) g = 2;
      else if (m_pend[0]) g = 0;
      else if (m_pend[1]) g = 1;
    end
    for (int b = 0; b < 3; b++) begin
      if (ev[b] && m_pend[b] && g != b) m_ovr = 1;
      m_pend[b] = en && ((m_pend[b] && g != b) || ev[b]);
    end
    if (!en) begin
      m_q.delete(); m_valid = 0; m_code = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      m_valid = (m_q.size() != 0);
      m_code  = m_valid ? m_q[0] : 2'b00;
      if (g >= 0) m_q.push_back(2'(g + 1));
    end
    for (int b = 0; b < 3; b++) begin
      m_dbp[b] = m_db[b];
      if (m_s2[b] != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] >= D) begin m_db[b] = !m_db[b]; m_run[b] = 0; end
      end else m_run[b] = 0;
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  task automatic tick();
    @(posedge buttonclk);
    model_step(reset, enable, raws, cmd_ready);
    #1;
    chk("model_valid", cmd_valid, m_valid);
    chk("model_code", cmd_code, m_code);
    chk("model_count", fifo_count, m_q.size());
    chk("model_overrun", overrun, m_ovr);
  endtask

  task automatic apply_reset();
    reset = 1; enable = 1; cmd_ready = 0; raws = '0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic press(input int b, input int hold);
    raws[b] = 1'b1;
    repeat (hold) tick();
    raws[b] = 1'b0;
    repeat (8) tick();
  endtask

  typedef struct {
    logic [2:0] btn;
    int         hold;
    logic       rdy;
    int         exp_cnt;
    logic [1:0] exp_code;
    logic       exp_ovr;
  } vec_t;

  vec_t       vt[12];
  logic [2:0] lvl;
  logic [1:0] drain[4];

  initial begin
    vt[0]  = '{3'b100,  1, 1'b0, 0, 2'b00, 1'b0}; // throw glitch
    vt[1]  = '{3'b001,  1, 1'b0, 0, 2'b00, 1'b0}; // D-1 sync'd samples
    vt[2]  = '{3'b100,  2, 1'b0, 1, 2'b11, 1'b0}; // exactly D samples
    vt[3]  = '{3'b100, 20, 1'b0, 1, 2'b11, 1'b0}; // throw never repeats
    vt[4]  = '{3'b101,  4, 1'b0, 2, 2'b11, 1'b0}; // throw beats left
    vt[5]  = '{3'b011, 20, 1'b0, 0, 2'b00, 1'b0}; // left+right cancel
    vt[6]  = '{3'b010,  6, 1'b0, 1, 2'b10, 1'b0}; // one short of first repeat
    vt[7]  = '{3'b010,  7, 1'b0, 2, 2'b10, 1'b0}; // first repeat
    vt[8]  = '{3'b010, 14, 1'b0, 4, 2'b10, 1'b0}; // full, one pending
    vt[9]  = '{3'b010, 16, 1'b0, 4, 2'b10, 1'b1}; // merge -> overrun
    vt[10] = '{3'b001, 12, 1'b1, 0, 2'b00, 1'b0}; // drained as produced
    vt[11] = '{3'b100, 20, 1'b1, 0, 2'b00, 1'b0};

    apply_reset();
    chk("reset_valid", cmd_valid, 0);
    chk("reset_code", cmd_code, 0);
    chk("reset_count", fifo_count, 0);
    chk("reset_overrun", overrun, 0);

    foreach (vt[i]) begin
      apply_reset();
      cmd_ready = vt[i].rdy;
      raws = vt[i].btn;
      repeat (vt[i].hold) tick();
      raws = '0;
      repeat (15) tick();
      chk($sformatf("vec%0d_count", i), fifo_count, vt[i].exp_cnt);
      chk($sformatf("vec%0d_code", i), cmd_code, vt[i].exp_code);
      chk($sformatf("vec%0d_overrun", i), overrun, vt[i].exp_ovr);
    end

    // Latency: first sampling edge is edge 0, valid after edge 4+D.
    apply_reset();
    raws[2] = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) chk("lat_not_yet", cmd_valid, 0);
      if (e == 6) begin
        chk("lat_valid", cmd_valid, 1);
        chk("lat_code", cmd_code, 3);
      end
    end
    repeat (10) tick();
    chk("lat_one_entry", fifo_count, 1);
    raws = '0;

    // Full FIFO, pending throw, overrun, then full+pop push.
    apply_reset();
    press(0, 3); press(1, 3); press(0, 3); press(1, 3);
    chk("full_count", fifo_count, 4);
    press(2, 3);
    chk("full_blocked_count", fifo_count, 4);
    chk("full_no_overrun", overrun, 0);
    press(2, 3);
    chk("full_overrun", overrun, 1);
    cmd_ready = 1;
    tick();
    chk("pop_push_count", fifo_count, 4);
    drain[0] = 2'b10; drain[1] = 2'b01; drain[2] = 2'b10; drain[3] = 2'b11;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain%0d_code", j), cmd_code, drain[j]);
      tick();
    end
    chk("drained_valid", cmd_valid, 0);
    chk("drained_count", fifo_count, 0);
    cmd_ready = 0;

    // Enable low flushes but keeps overrun; held button across enable rise.
    press(0, 3); press(2, 3);
    chk("pre_flush_count", fifo_count, 2);
    enable = 0;
    raws[1] = 1'b1;
    tick();
    chk("flush_count", fifo_count, 0);
    chk("flush_valid", cmd_valid, 0);
    chk("flush_keeps_overrun", overrun, 1);
    repeat (7) tick();
    enable = 1;
    repeat (12) tick();
    chk("held_across_enable", fifo_count, 0);
    raws[1] = 1'b0;
    repeat (8) tick();

    // Reset mid-queue.
    press(0, 3); press(1, 3);
    chk("pre_reset_count", fifo_count, 2);
    reset = 1;
    tick();
    chk("midreset_count", fifo_count, 0);
    chk("midreset_valid", cmd_valid, 0);
    chk("midreset_overrun", overrun, 0);
    reset = 0;

    // Randomised run against the model.
    lvl = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 9) == 0) lvl[b] = ~lvl[b];
      raws = lvl ^ (($urandom_range(0, 29) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000);
      if (c % 500 < 250) cmd_ready = ($urandom_range(0, 3) == 0);
      else               cmd_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 199) != 0);
      reset  = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
